// File: rtl/seq_divider8.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
// One trial subtraction per clock; a zero divisor finishes in a single step.
module seq_divider8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateType;

    stateType         state, stateNext;
    logic [WIDTH-1:0] rReg, rNext, qReg, qNext, dReg, dNext;
    logic [WIDTH-1:0] quotientNext, remainderNext;
    logic [CW-1:0]    count, countNext;
    logic             busyNext, doneNext, dbzNext;
    logic [RW-1:0]    rShift, diff;
    logic             noBorrow;

    // Partial remainder shifted left with the next dividend bit; the extra bit keeps
    // the carried-out MSB when the divisor exceeds half range.
    assign rShift = {rReg, qReg[WIDTH-1]};
    assign {noBorrow, diff} = {1'b0, rShift} + {1'b0, ~{1'b0, dReg}} + (RW + 1)'(1);

    always_comb begin
        stateNext     = state;
        rNext         = rReg;
        qNext         = qReg;
        dNext         = dReg;
        countNext     = count;
        quotientNext  = quotient;
        remainderNext = remainder;
        dbzNext       = dbz;

        case (state)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        dNext     = divisor;
                        qNext     = dividend;
                        rNext     = '0;
                        countNext = '0;
                        stateNext = RUN;
                    end else begin
                        quotientNext  = '1;
                        remainderNext = dividend;
                        dbzNext       = 1'b1;
                        stateNext     = DONE;
                    end
                end
            end
            RUN: begin
                rNext     = WIDTH'(noBorrow ? diff : rShift);
                qNext     = {qReg[WIDTH-2:0], noBorrow};
                countNext = CW'(count + CW'(1));
                if (count == LAST_STEP) begin
                    quotientNext  = qNext;
                    remainderNext = rNext;
                    dbzNext       = 1'b0;
                    stateNext     = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        busyNext = (stateNext != IDLE);
        doneNext = (stateNext == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rReg      <= '0;
            qReg      <= '0;
            dReg      <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            state     <= stateNext;
            rReg      <= rNext;
            qReg      <= qNext;
            dReg      <= dNext;
            count     <= countNext;
            busy      <= busyNext;
            done      <= doneNext;
            quotient  <= quotientNext;
            remainder <= remainderNext;
            dbz       <= dbzNext;
        end
    end

endmodule

// File: tb/tb_seq_divider8.sv
// Bench for seq_divider8: a timeline model built on / and % predicts every output
// each cycle; directed cases pin the model and the handshake timing to literals.
module tb_seq_divider8;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, dbz;
    logic [W-1:0] quotient, remainder;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_divider8 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .dbz      (dbz)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at time %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request finishes WIDTH edges later (same edge for
    // divisor 0), stays in its done cycle for one edge, and only then accepts again.
    int           edgeNo   = 0;
    int           doneEdge = 0;
    bit           active   = 1'b0;
    logic         expBusy  = 1'b0;
    logic         expDone  = 1'b0;
    logic         expDbz   = 1'b0;
    logic [W-1:0] expQ     = '0;
    logic [W-1:0] expR     = '0;
    logic [W-1:0] pendQ    = '0;
    logic [W-1:0] pendR    = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edgeNo  = 0;
            active  = 1'b0;
            expBusy = 1'b0;
            expDone = 1'b0;
            expDbz  = 1'b0;
            expQ    = '0;
            expR    = '0;
        end else begin
            edgeNo++;
            expDone = 1'b0;
            if (active && edgeNo == doneEdge) begin
                expDone = 1'b1;
                expQ    = pendQ;
                expR    = pendR;
                expDbz  = 1'b0;
            end else if (active && edgeNo == doneEdge + 1) begin
                active  = 1'b0;
                expBusy = 1'b0;
            end else if (!active && start) begin
                active  = 1'b1;
                expBusy = 1'b1;
                if (divisor == '0) begin
                    expDone  = 1'b1;
                    expQ     = '1;
                    expR     = dividend;
                    expDbz   = 1'b1;
                    doneEdge = edgeNo;
                end else begin
                    pendQ    = dividend / divisor;
                    pendR    = dividend % divisor;
                    doneEdge = edgeNo + int'(W);
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(expBusy));
        check("done", 32'(done), 32'(expDone));
        check("quotient", 32'(quotient), 32'(expQ));
        check("remainder", 32'(remainder), 32'(expR));
        check("dbz", 32'(dbz), 32'(expDbz));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", fails);
        $fatal(1, "watchdog expired");
    end

    // Issue one request at a negedge and return at the negedge where done is seen.
    task automatic runDiv(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic busy1);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        lat      = 0;
        busy1    = 1'b0;
        do begin
            @(negedge clk);
            start    = 1'b0;
            dividend = W'($urandom);
            divisor  = W'($urandom);
            lat++;
            if (lat == 1) busy1 = busy;
        end while (!done && lat < 20);
    endtask

    function automatic logic [W-1:0] pickDivisor();
        case ($urandom % 8)
            0:       return '0;
            1:       return W'(1);
            2:       return '1;
            3:       return W'(128 + ($urandom % 128));
            4:       return W'(1 + ($urandom % 15));
            default: return W'($urandom);
        endcase
    endfunction

    int va[7] = '{200, 255, 5, 255, 255, 77, 10};
    int vb[7] = '{7, 1, 9, 255, 128, 0, 3};
    int vq[7] = '{28, 255, 0, 1, 1, 255, 3};
    int vr[7] = '{4, 0, 5, 0, 127, 77, 1};

    initial begin
        int   lat;
        logic busy1;
        int   doneCount;
        int   ops;
        int   cyc;

        rst_n    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset dbz", 32'(dbz), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed results: done is seen WIDTH+1 negedges after start is driven
        // (busy the first), or on the very next negedge for a zero divisor.
        for (int i = 0; i < 7; i++) begin
            runDiv(W'(va[i]), W'(vb[i]), lat, busy1);
            check("latency", 32'(lat), (vb[i] == 0) ? 32'd1 : 32'(W + 1));
            check("busy after start", 32'(busy1), 32'd1);
            check("directed quotient", 32'(quotient), 32'(vq[i]));
            check("directed remainder", 32'(remainder), 32'(vr[i]));
            check("directed dbz", 32'(dbz), (vb[i] == 0) ? 32'd1 : 32'd0);
            check("model quotient", 32'(expQ), 32'(vq[i]));
            check("model remainder", 32'(expR), 32'(vr[i]));
            @(negedge clk);
            check("done single pulse", 32'(done), 32'd0);
            check("busy after done", 32'(busy), 32'd0);
        end

        // Requests during RUN and in the done cycle are dropped.
        dividend  = W'(100);
        divisor   = W'(10);
        start     = 1'b1;
        doneCount = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                doneCount++;
                start    = 1'b1;
                dividend = W'(9);
                divisor  = W'(2);
            end
            if (c == 3 || c == 8) begin
                start    = 1'b1;
                dividend = W'(9);
                divisor  = W'(2);
            end
        end
        start = 1'b0;
        check("ignored start done count", 32'(doneCount), 32'd1);
        check("ignored start quotient", 32'(quotient), 32'd10);
        check("ignored start remainder", 32'(remainder), 32'd0);
        check("ignored start dbz", 32'(dbz), 32'd0);

        // Asynchronous reset in the middle of a division.
        dividend = W'(200);
        divisor  = W'(7);
        start    = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort quotient", 32'(quotient), 32'd0);
        check("abort remainder", 32'(remainder), 32'd0);
        check("abort dbz", 32'(dbz), 32'd0);
        doneCount = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        check("abort no done", 32'(doneCount), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        runDiv(W'(50), W'(6), lat, busy1);
        check("post-reset latency", 32'(lat), 32'(W + 1));
        check("post-reset quotient", 32'(quotient), 32'd8);
        check("post-reset remainder", 32'(remainder), 32'd2);
        @(negedge clk);

        // Random traffic: new requests on the first idle cycle, noise starts while busy.
        ops = 0;
        cyc = 0;
        while (ops < 2000 && cyc < 40000) begin
            if (!busy && ($urandom % 4 != 0)) begin
                start    = 1'b1;
                dividend = ($urandom % 4 == 0) ? W'($urandom % 16) : W'($urandom);
                divisor  = pickDivisor();
                ops++;
            end else begin
                start    = busy ? 1'($urandom % 2) : 1'b0;
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("random ops issued", 32'(ops), 32'd2000);
        repeat (W + 4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
